// File: rtl/universal_shiftreg_n.sv
// Parametrised universal shift register: load/clear/hold plus shifts and rotates by a
// programmable amount, executed one bit per clock under a start/busy/done handshake.
module universal_shiftreg_n #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MODE,
    input  logic [SHW-1:0]   SHAMT,
    input  logic [WIDTH-1:0] DATAIN,
    input  logic             SIN_R,
    input  logic             SIN_L,
    output logic [WIDTH-1:0] DATAOUT,
    output logic             SOUT,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LSR  = 3'b001;
    localparam logic [2:0] MODE_SL   = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             sout_q,  sout_d;
    logic             done_q,  done_d;
    logic             busy_q;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    logic [2:0]       mode_q,  mode_d;

    // One 1-bit step of a shift/rotate mode; result is {bit shifted out, new data}.
    function automatic logic [WIDTH:0] step_f(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] d,
        input logic             sr,
        input logic             sl
    );
        case (m)
            MODE_LSR: step_f = {d[0],       sr,         d[WIDTH-1:1]};
            MODE_SL:  step_f = {d[WIDTH-1], d[WIDTH-2:0], sl};
            MODE_ROR: step_f = {d[0],       d[0],       d[WIDTH-1:1]};
            MODE_ROL: step_f = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            MODE_ASR: step_f = {d[0],       d[WIDTH-1], d[WIDTH-1:1]};
            default:  step_f = {1'b0, d};
        endcase
    endfunction

    // Next-state logic: accept in IDLE, one step per clock in SHIFT.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (MODE)
                        MODE_HOLD: begin
                            done_d = 1'b1;
                        end
                        MODE_LOAD: begin
                            data_d = DATAIN;
                            done_d = 1'b1;
                        end
                        MODE_CLR: begin
                            data_d = {WIDTH{1'b0}};
                            sout_d = 1'b0;
                            done_d = 1'b1;
                        end
                        default: begin
                            // Shift amount 0 is a no-op that still completes the handshake.
                            if (SHAMT == {SHW{1'b0}}) begin
                                done_d = 1'b1;
                            end else begin
                                {sout_d, data_d} = step_f(MODE, data_q, SIN_R, SIN_L);
                                if (SHAMT == SHW'(1)) begin
                                    done_d = 1'b1;
                                end else begin
                                    cnt_d   = SHAMT - SHW'(1);
                                    mode_d  = MODE;
                                    state_d = ST_SHIFT;
                                end
                            end
                        end
                    endcase
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                {sout_d, data_d} = step_f(mode_q, data_q, SIN_R, SIN_L);
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any shift in progress without a done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            data_q  <= {WIDTH{1'b0}};
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= {SHW{1'b0}};
            mode_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            busy_q  <= (state_d == ST_SHIFT);
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign DATAOUT = data_q;
    assign SOUT    = sout_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_universal_shiftreg_n.sv
// Scoreboard bench for universal_shiftreg_n (WIDTH=8): directed cases from the test plan
// followed by randomized operations checked against an arithmetic reference model.
module tb_universal_shiftreg_n;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   MODE = 3'b000;
    logic [2:0]   SHAMT = 3'b000;
    logic [W-1:0] DATAIN = 8'h00;
    logic         SIN_R = 1'b0;
    logic         SIN_L = 1'b0;
    logic [W-1:0] DATAOUT;
    logic         SOUT;
    logic         busy;
    logic         done;

    universal_shiftreg_n #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .MODE(MODE), .SHAMT(SHAMT),
        .DATAIN(DATAIN), .SIN_R(SIN_R), .SIN_L(SIN_L),
        .DATAOUT(DATAOUT), .SOUT(SOUT), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] data;
        logic         sout;
        int           acc_cyc;
        int           exp_cyc;
        int           k;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_err = 0;
    logic [W-1:0] m_data = 8'h00;
    logic         m_sout = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole operation computed at once from the mode's definition.
    task automatic model_apply(input logic [2:0] m, input int k, input logic [W-1:0] din,
                               input logic sr, input logic sl);
        logic [W-1:0] d;
        logic [W-1:0] ones;
        d    = m_data;
        ones = 8'hFF;
        case (m)
            3'd1: if (k > 0) begin m_data = (d >> k) | (sr ? ~(ones >> k) : 8'h00); m_sout = d[k-1]; end
            3'd2: if (k > 0) begin m_data = (d << k) | (sl ? ~(ones << k) : 8'h00); m_sout = d[W-k]; end
            3'd3: m_data = din;
            3'd4: if (k > 0) begin m_data = (d >> k) | (d << (W-k)); m_sout = d[k-1]; end
            3'd5: if (k > 0) begin m_data = (d << k) | (d >> (W-k)); m_sout = d[W-k]; end
            3'd6: if (k > 0) begin m_data = $signed(d) >>> k; m_sout = d[k-1]; end
            3'd7: begin m_data = 8'h00; m_sout = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] m, input int k, input logic [W-1:0] din,
                         input logic sr, input logic sl);
        exp_t e;
        bit   is_shift;
        MODE   = m;
        SHAMT  = 3'(k);
        DATAIN = din;
        SIN_R  = sr;
        SIN_L  = sl;
        start  = 1'b1;
        model_apply(m, k, din, sr, sl);
        is_shift  = (m != 3'd0) && (m != 3'd3) && (m != 3'd7);
        e.data    = m_data;
        e.sout    = m_sout;
        e.acc_cyc = cyc;
        e.k       = is_shift ? k : 0;
        e.exp_cyc = cyc + ((e.k >= 2) ? e.k : 1);
        sb.push_back(e);
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0) return;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: checks busy every cycle and pops one expectation per done pulse.
    always @(negedge clock) begin
        if (reset) begin
            logic exp_busy;
            exp_busy = (sb.size() > 0) && (sb[0].k >= 2) && (cyc > sb[0].acc_cyc) && (cyc < sb[0].exp_cyc);
            chk("busy", busy, exp_busy);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", done, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("dataout", DATAOUT, e.data);
                    chk("sout", SOUT, e.sout);
                    chk("done_cycle", cyc, e.exp_cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset asserted with random inputs present.
        MODE = 3'($urandom); DATAIN = 8'($urandom); SHAMT = 3'($urandom);
        #2 reset = 1'b0;
        #1;
        chk("rst_dataout", DATAOUT, 8'h00);
        chk("rst_sout", SOUT, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1 chk("hold_after_rst", DATAOUT, 8'h00);
        end

        // Directed cases.
        issue(3'd3, 0, 8'hA5, 1'b0, 1'b0); wait_idle();
        issue(3'd1, 3, 8'h00, 1'b0, 1'b0); wait_idle();
        issue(3'd1, 0, 8'h00, 1'b0, 1'b0); wait_idle();
        issue(3'd3, 0, 8'h81, 1'b0, 1'b0); wait_idle();
        issue(3'd2, 2, 8'h00, 1'b0, 1'b1); wait_idle();
        issue(3'd3, 0, 8'h90, 1'b0, 1'b0); wait_idle();
        issue(3'd6, 2, 8'h00, 1'b0, 1'b0); wait_idle();
        issue(3'd3, 0, 8'h3C, 1'b0, 1'b0); wait_idle();
        issue(3'd5, 4, 8'h00, 1'b0, 1'b0); wait_idle();
        issue(3'd4, 4, 8'h00, 1'b0, 1'b0); wait_idle();

        // Start with clear while a 7-step shift is busy must be ignored.
        issue(3'd3, 0, 8'h6B, 1'b0, 1'b0); wait_idle();
        issue(3'd1, 7, 8'h00, 1'b1, 1'b0);
        MODE = 3'd7; SHAMT = 3'd1; DATAIN = 8'hFF; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_idle();

        // Reset at step 3 of a 7-step shift: immediate clear, no done afterwards.
        issue(3'd3, 0, 8'hC7, 1'b0, 1'b0); wait_idle();
        issue(3'd2, 7, 8'h00, 1'b0, 1'b1);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("abort_dataout", DATAOUT, 8'h00);
        chk("abort_sout", SOUT, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        sb.delete();
        m_data = 8'h00;
        m_sout = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            #1;
            chk("abort_no_done", done, 1'b0);
            chk("abort_hold", DATAOUT, 8'h00);
        end

        // Randomized operations, mostly back-to-back in the done cycle.
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
            issue(3'($urandom_range(0, 7)), $urandom_range(0, 7), 8'($urandom),
                  1'($urandom), 1'($urandom));
            wait_idle();
        end

        repeat (3) @(negedge clock);
        #1;
        chk("final_dataout", DATAOUT, m_data);
        chk("final_sout", SOUT, m_sout);
        chk("final_queue_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/universal_shiftreg_n.md
Name: universal_shiftreg_n

Overview:
Parametrised universal shift register. It adds these features to the fixed 4-bit, 2-bit-mode unit: configurable width, rotate, arithmetic right shift, clear, serial in/out, and multi-bit shifts by a programmable amount. Multi-bit shifts execute one bit per clock under a start/busy/done handshake. It is used as a datapath building block for serialisers and barrel-shift replacement where area matters more than latency.

Parameters:
WIDTH, 8, register width in bits (>=2)
SHW, $clog2(WIDTH), width of shift-amount input (derived localparam, not overridable)

Ports:
clock  input  1  single system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request operation; sampled only when busy=0
MODE  input  3  operation select, sampled with start
SHAMT  input  SHW  shift/rotate amount, sampled with start
DATAIN  input  WIDTH  parallel load value, sampled with start
SIN_R  input  1  serial fill bit entering MSB on logical right shift
SIN_L  input  1  serial fill bit entering LSB on left shift
DATAOUT  output  WIDTH  register contents
SOUT  output  1  last bit shifted/rotated out
busy  output  1  multi-cycle shift in progress
done  output  1  one-cycle pulse: operation complete

Behaviour:
- Reset (reset=0, async): DATAOUT=0, SOUT=0, busy=0, done=0, counter=0, state IDLE. Reset mid-shift aborts immediately; no done pulse.
- MODE encoding:
  - 000 hold
  - 001 logical shift right (MSB<=SIN_R)
  - 010 shift left (LSB<=SIN_L)
  - 011 parallel load DATAIN
  - 100 rotate right
  - 101 rotate left
  - 110 arithmetic shift right (MSB replicated)
  - 111 clear
- States: IDLE, SHIFT. busy = (state==SHIFT), registered.
- Accept: start=1 and busy=0 on a rising edge. start while busy=1 is ignored; MODE/SHAMT/DATAIN changes while busy have no effect (mode latched at accept).
- Single-cycle ops (hold, load, clear, any shift/rotate with SHAMT=0, any shift/rotate with SHAMT=1):
  - Update at accept edge.
  - done=1 for the following cycle.
  - State stays IDLE.
- Multi-cycle (shift/rotate modes, SHAMT>=2):
  - Accept edge: first 1-bit step, counter<=SHAMT-1, state<=SHIFT.
  - Each SHIFT edge: one 1-bit step, counter decrements.
  - At the edge where counter==1: last step, state<=IDLE, done<=1.
  - Final DATAOUT is valid after SHAMT edges counting the accept edge; done is high in the cycle after the final update, with busy already 0.
- SIN_R/SIN_L are sampled live at each step edge, not latched at accept.
- SOUT updates at every step:
  - right-direction modes: old bit0
  - left-direction modes: old bit WIDTH-1
  - load and hold: unchanged
  - clear: SOUT<=0
- done is deasserted on every cycle except the one-cycle pulse. Back-to-back: start may be accepted in the cycle where done=1.
- SHAMT range 0..WIDTH-1 (no modulo needed). Rotate by k then by WIDTH-k restores the value.
- No combinational path from inputs to outputs.

Test Plan:
All scenarios use WIDTH=8.
- Reset: assert reset=0 mid-run with random inputs -> DATAOUT=0x00, SOUT=0, busy=0, done=0 immediately (before next clock edge); release -> values hold until start.
- Load: start, MODE=011, DATAIN=0xA5 -> DATAOUT=0xA5 after one edge; done high exactly one cycle; busy never asserts.
- Logical right shift: from 0xA5, MODE=001, SHAMT=3, SIN_R=0 -> busy high 2 cycles, DATAOUT=0x14, SOUT=1, done pulse next cycle. Same with SHAMT=0 -> DATAOUT unchanged, done after one edge.
- Left shift and arithmetic right:
  - 0x81, MODE=010, SHAMT=2, SIN_L=1 -> 0x07, SOUT=0.
  - 0x90, MODE=110, SHAMT=2 -> 0xE4, SOUT=0.
- Rotate: 0x3C, MODE=101, SHAMT=4 -> 0xC3, SOUT=1; then MODE=100, SHAMT=4 -> 0x3C.
- Handshake and abort:
  - start with MODE=111 while busy on a SHAMT=7 shift -> ignored; shift completes normally.
  - Issue start in the done cycle -> accepted.
  - Assert reset at step 3 of a 7-step shift -> DATAOUT=0x00, no done pulse.
